// File: rtl/result_demux_16.sv
// Routes one word to a chosen lane (1-cycle latency) or broadcasts it to all 16 lanes, one lane per cycle.
// in_ready drops while the target lane is full and unacked, and for the whole broadcast sequence.
module result_demux_16 #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [3:0]            in_sel,
  input  logic                  in_bcast,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [16*WIDTH-1:0]   out_bus,
  output logic [15:0]           lane_valid,
  input  logic [15:0]           lane_ack,
  output logic                  bcast_done,
  output logic [7:0]            write_count
);

  typedef enum logic {IDLE, BCAST} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] bcast_word;

  logic             wr_en;
  logic [3:0]       wr_lane;
  logic [WIDTH-1:0] wr_data;

  // A lane may be written when it is empty or being drained in the same cycle.
  always_comb begin
    in_ready = 1'b0;
    wr_en    = 1'b0;
    wr_lane  = in_sel;
    wr_data  = in_data;
    if (state == IDLE) begin
      in_ready = in_bcast | ~lane_valid[in_sel] | lane_ack[in_sel];
      wr_en    = in_valid & in_ready & ~in_bcast;
    end else begin
      wr_lane  = cnt;
      wr_data  = bcast_word;
      wr_en    = ~lane_valid[cnt] | lane_ack[cnt];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      bcast_word  <= '0;
      out_bus     <= '0;
      lane_valid  <= '0;
      bcast_done  <= 1'b0;
      write_count <= 8'd0;
    end else begin
      bcast_done <= 1'b0;
      // Acks clear their lanes; a write to the same lane overrides the clear.
      lane_valid <= lane_valid & ~lane_ack;
      if (wr_en) begin
        out_bus[wr_lane*WIDTH +: WIDTH] <= wr_data;
        lane_valid[wr_lane]             <= 1'b1;
        if (write_count != 8'hFF) begin
          write_count <= write_count + 8'd1;
        end
      end
      case (state)
        IDLE: begin
          if (in_valid && in_ready && in_bcast) begin
            bcast_word <= in_data;
            cnt        <= 4'd0;
            state      <= BCAST;
          end
        end
        BCAST: begin
          if (wr_en) begin
            if (cnt == 4'd15) begin
              state      <= IDLE;
              bcast_done <= 1'b1;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_demux_16.sv
// Scoreboard bench for result_demux_16: per-lane expected queues filled at transfer time,
// drained by a monitor whenever a lane is consumed (lane_valid & lane_ack).
module tb_result_demux_16;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  in_data;
  logic [3:0]   in_sel;
  logic         in_bcast;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] out_bus;
  logic [15:0]  lane_valid;
  logic [15:0]  lane_ack;
  logic         bcast_done;
  logic [7:0]   write_count;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [15:0] exp_q [0:15][$];

  result_demux_16 #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
    .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready),
    .out_bus(out_bus), .lane_valid(lane_valid), .lane_ack(lane_ack),
    .bcast_done(bcast_done), .write_count(write_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lane_dat(input int i);
    return out_bus[i*16 +: 16];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push_all(input logic [15:0] d);
    for (int i = 0; i < 16; i++) exp_q[i].push_back(d);
  endtask

  task automatic write1(input logic [3:0] sel, input logic [15:0] d);
    bit ok;
    ok = 0;
    sync();
    in_valid = 1'b1; in_bcast = 1'b0; in_sel = sel; in_data = d;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        exp_q[sel].push_back(d);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (!ok) chk("write_timeout", 32'd0, 32'd1);
    else sync();
    in_valid = 1'b0;
  endtask

  task automatic ack_lanes(input logic [15:0] m);
    sync();
    lane_ack = m;
    sync();
    lane_ack = '0;
  endtask

  // Consumption monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (bcast_done) done_cnt++;
      for (int i = 0; i < 16; i++) begin
        if (lane_valid[i] && lane_ack[i]) begin
          n_cmp++;
          if (exp_q[i].size() == 0) begin
            n_bad++;
            $display("FAIL lane%0d_unexpected: got %0h expected nothing", i, lane_dat(i));
          end else begin
            logic [15:0] e;
            e = exp_q[i].pop_front();
            if (lane_dat(i) !== e) begin
              n_bad++;
              $display("FAIL lane%0d_data: got %0h expected %0h", i, lane_dat(i), e);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nz;
    int d0;
    int left;
    bit seen;
    reset = 1'b1; in_data = '0; in_sel = '0; in_bcast = 1'b0; in_valid = 1'b0; lane_ack = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_lane_valid", lane_valid, 0);
    chk("rst_bus_zero", out_bus == '0, 1);
    chk("rst_write_count", write_count, 0);
    chk("rst_bcast_done", bcast_done, 0);
    chk("rst_in_ready", in_ready, 1);

    // Single write
    write1(4'd5, 16'hBEEF);
    @(negedge clk);
    chk("single_lane_valid", lane_valid, 32'h0020);
    chk("single_data", lane_dat(5), 16'hBEEF);
    chk("single_wc", write_count, 1);
    ack_lanes(16'h0020);
    @(negedge clk);
    chk("single_drained", lane_valid, 0);

    // Occupied stall, then write+ack on the same lane
    write1(4'd3, 16'h1111);
    sync();
    in_valid = 1'b1; in_sel = 4'd3; in_data = 16'h2222;
    @(negedge clk);
    chk("stall_ready", in_ready, 0);
    sync();
    @(negedge clk);
    chk("stall_ready2", in_ready, 0);
    chk("stall_hold_data", lane_dat(3), 16'h1111);
    sync();
    lane_ack = 16'h0008;
    @(negedge clk);
    chk("ack_ready", in_ready, 1);
    exp_q[3].push_back(16'h2222);
    sync();
    in_valid = 1'b0; lane_ack = '0;
    @(negedge clk);
    chk("wwins_valid", lane_valid, 32'h0008);
    chk("wwins_data", lane_dat(3), 16'h2222);
    chk("wwins_wc", write_count, 3);
    ack_lanes(16'h0200);
    @(negedge clk);
    chk("ack_empty_ignored", lane_valid, 32'h0008);
    ack_lanes(16'h0008);

    // Broadcast with all lanes free
    sync();
    in_valid = 1'b1; in_bcast = 1'b1; in_data = 16'h00A5; in_sel = 4'd3;
    @(negedge clk);
    chk("bc_ready", in_ready, 1);
    push_all(16'h00A5);
    sync();
    in_valid = 1'b0; in_bcast = 1'b0;
    d0 = done_cnt; nz = 0; seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bcast_done) seen = 1;
      else if (!in_ready) nz++;
    end
    chk("bc_busy_cycles", nz, 16);
    repeat (3) sync();
    chk("bc_done_once", done_cnt - d0, 1);
    @(negedge clk);
    chk("bc_lane_valid", lane_valid, 32'hFFFF);
    chk("bc_wc", write_count, 19);
    for (int i = 0; i < 16; i++) chk($sformatf("bc_lane%0d", i), lane_dat(i), 16'h00A5);
    ack_lanes(16'hFFFF);
    @(negedge clk);
    chk("bc_drained", lane_valid, 0);

    // Broadcast stalled on occupied lane 7, with an independent ack on lane 2
    write1(4'd7, 16'h7777);
    sync();
    in_valid = 1'b1; in_bcast = 1'b1; in_data = 16'h5A5A;
    @(negedge clk);
    chk("bcs_ready", in_ready, 1);
    push_all(16'h5A5A);
    sync();
    in_valid = 1'b0; in_bcast = 1'b0;
    repeat (12) sync();
    @(negedge clk);
    chk("bcs_held_at7", lane_valid, 32'h00FF);
    chk("bcs_ready_low", in_ready, 0);
    sync();
    lane_ack = 16'h0084;
    sync();
    lane_ack = '0;
    d0 = done_cnt;
    @(negedge clk);
    chk("bcs_after_ack", lane_valid, 32'h00FB);
    chk("bcs_lane7_new", lane_dat(7), 16'h5A5A);
    nz = 0; seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bcast_done) seen = 1;
      else nz++;
    end
    chk("bcs_done_delay", nz, 7);
    repeat (3) sync();
    chk("bcs_done_once", done_cnt - d0, 1);
    @(negedge clk);
    chk("bcs_lane_valid", lane_valid, 32'hFFFB);
    chk("bcs_wc", write_count, 36);
    ack_lanes(16'hFFFB);

    // Reset in the middle of a broadcast
    sync();
    in_valid = 1'b1; in_bcast = 1'b1; in_data = 16'h1234;
    @(negedge clk);
    push_all(16'h1234);
    sync();
    in_valid = 1'b0; in_bcast = 1'b0;
    repeat (8) sync();
    @(negedge clk);
    chk("mid_bc_progress", lane_valid, 32'h00FF);
    sync();
    reset = 1'b1;
    sync();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) exp_q[i].delete();
    d0 = done_cnt;
    @(negedge clk);
    chk("mrst_lane_valid", lane_valid, 0);
    chk("mrst_bus_zero", out_bus == '0, 1);
    chk("mrst_wc", write_count, 0);
    chk("mrst_done", bcast_done, 0);
    chk("mrst_ready", in_ready, 1);
    repeat (20) sync();
    chk("mrst_no_done", done_cnt - d0, 0);

    // Saturating write counter
    for (int i = 0; i < 260; i++) begin
      write1(4'(i % 16), 16'(i));
      ack_lanes(16'h1 << (i % 16));
      if (i == 253) begin
        @(negedge clk);
        chk("sat_254", write_count, 254);
      end
    end
    @(negedge clk);
    chk("sat_255", write_count, 255);

    left = 0;
    for (int i = 0; i < 16; i++) left += exp_q[i].size();
    chk("queues_drained", left, 0);
    chk("total_done", done_cnt, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
